uart_cmd_framer: RTL and testbench

UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_frame_timer.sv | 39 +++
 rtl/uart_cmd_framer.sv | 144 ++++++++++++++
 tb/tb_uart_cmd_framer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command framer.
// State encoding, error codes and the default start-of-frame marker.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StGetCmd,
      StGetArg,
      StGetChk,
      StHold
   } frame_state_e;

   localparam logic [1:0] ERR_CHK = 2'b01;
   localparam logic [1:0] ERR_OVR = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   localparam logic [7:0] SOF_DEFAULT = 8'hAA;

   // Frame check byte: CMD XOR ARG.
   function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
      return cmd ^ arg;
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for the UART command framer.
// Counts while run is high, clears on clr; expired marks the last counted cycle.
module uart_frame_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 520800
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expired = run && (cnt_q == CntMax);

   // Next count: clear wins, restart after expiry so the next frame starts fresh.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || expired) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_framer.sv
// UART command framer: parses SOF, CMD, ARG, CHK frames from a byte stream and
// presents validated commands on a valid/ready handshake.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_framer
   import uart_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 520800,
   parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_code,
   output logic [7:0] cmd_arg,
   output logic       err_valid,
   output logic [1:0] err_code
);

   frame_state_e state_q, state_d;
   logic [7:0]   cmd_byte_q, cmd_byte_d;
   logic [7:0]   arg_byte_q, arg_byte_d;
   logic [7:0]   cmd_code_q, cmd_code_d;
   logic [7:0]   cmd_arg_q, cmd_arg_d;
   logic         err_valid_q, err_valid_d;
   logic [1:0]   err_code_q, err_code_d;
   logic         tmo_expired;

`ifdef UART_CMD_TIMEOUT_EN
   logic tmo_run;

   assign tmo_run = (state_q == StGetCmd) || (state_q == StGetArg) || (state_q == StGetChk);

   uart_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (rx_valid),
      .run     (tmo_run),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   // Parser next-state, byte capture and error generation.
   always_comb begin
      state_d     = state_q;
      cmd_byte_d  = cmd_byte_q;
      arg_byte_d  = arg_byte_q;
      cmd_code_d  = cmd_code_q;
      cmd_arg_d   = cmd_arg_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;

      unique case (state_q)
         StIdle: begin
            if (rx_valid && (rx_data == SOF_BYTE)) begin
               state_d = StGetCmd;
            end
         end
         StGetCmd: begin
            // A byte always beats a simultaneous timeout.
            if (rx_valid) begin
               cmd_byte_d = rx_data;
               state_d    = StGetArg;
            end else if (tmo_expired) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = StIdle;
            end
         end
         StGetArg: begin
            if (rx_valid) begin
               arg_byte_d = rx_data;
               state_d    = StGetChk;
            end else if (tmo_expired) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = StIdle;
            end
         end
         StGetChk: begin
            if (rx_valid) begin
               if (rx_data == frame_chk(cmd_byte_q, arg_byte_q)) begin
                  cmd_code_d = cmd_byte_q;
                  cmd_arg_d  = arg_byte_q;
                  state_d    = StHold;
               end else begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_CHK;
                  state_d     = StIdle;
               end
            end else if (tmo_expired) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_TMO;
               state_d     = StIdle;
            end
         end
         StHold: begin
            // Overrun drops the byte; the held command is untouched.
            if (rx_valid) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_OVR;
            end
            if (cmd_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cmd_byte_q  <= '0;
         arg_byte_q  <= '0;
         cmd_code_q  <= '0;
         cmd_arg_q   <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_byte_q  <= cmd_byte_d;
         arg_byte_q  <= arg_byte_d;
         cmd_code_q  <= cmd_code_d;
         cmd_arg_q   <= cmd_arg_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign cmd_valid = (state_q == StHold);
   assign cmd_code  = cmd_code_q;
   assign cmd_arg   = cmd_arg_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: table of frames plus hand-written
// overrun, same-cycle handshake, reset and timeout sequences.
module tb_uart_cmd_framer;

   localparam int unsigned TMO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic [7:0] cmd_arg;
   logic       err_valid;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] code;
      logic [7:0] arg;
   } cmd_t;

   typedef struct {
      logic [39:0] bytes;   // first byte in the top bits
      int          n;
      logic        exp_cmd;
      logic [7:0]  code;
      logic [7:0]  arg;
      logic        exp_err;
      logic [1:0]  ecode;
   } vec_t;

   cmd_t       exp_cmd_q[$];
   logic [1:0] exp_err_q[$];
   cmd_t       mon_cmd;
   logic [1:0] mon_err;
   vec_t       vecs[8];

   uart_cmd_framer #(
      .TIMEOUT_CYCLES(TMO),
      .SOF_BYTE      (8'hAA)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .cmd_arg   (cmd_arg),
      .err_valid (err_valid),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; strobes one byte for one cycle and returns at posedge+1.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare every handshake and error strobe against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: got code %0h arg %0h required none", cmd_code,
                        cmd_arg);
            end else begin
               mon_cmd = exp_cmd_q.pop_front();
               chk("cmd_code", 32'(cmd_code), 32'(mon_cmd.code));
               chk("cmd_arg", 32'(cmd_arg), 32'(mon_cmd.arg));
            end
         end
         if (err_valid) begin
            if (exp_err_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_err: got code %0h required none", err_code);
            end else begin
               mon_err = exp_err_q.pop_front();
               chk("err_code", 32'(err_code), 32'(mon_err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{40'hAA_F1_22_D3_00, 4, 1'b1, 8'hF1, 8'h22, 1'b0, 2'b00};
      vecs[1] = '{40'hAA_41_00_40_00, 4, 1'b0, 8'h00, 8'h00, 1'b1, 2'b01};
      vecs[2] = '{40'hAA_66_01_67_00, 4, 1'b1, 8'h66, 8'h01, 1'b0, 2'b00};
      vecs[3] = '{40'h12_AA_AA_00_AA, 5, 1'b1, 8'hAA, 8'h00, 1'b0, 2'b00};
      vecs[4] = '{40'hAA_00_00_00_00, 4, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00};
      vecs[5] = '{40'hAA_FF_AA_55_00, 4, 1'b1, 8'hFF, 8'hAA, 1'b0, 2'b00};
      vecs[6] = '{40'h55_AA_AA_AA_00, 5, 1'b1, 8'hAA, 8'hAA, 1'b0, 2'b00};
      vecs[7] = '{40'hAA_12_34_27_00, 4, 1'b0, 8'h00, 8'h00, 1'b1, 2'b01};

      // Reset state
      idle(2);
      chk("rst_cmd_valid", 32'(cmd_valid), 0);
      chk("rst_err_valid", 32'(err_valid), 0);
      chk("rst_cmd_code", 32'(cmd_code), 0);
      chk("rst_cmd_arg", 32'(cmd_arg), 0);
      chk("rst_err_code", 32'(err_code), 0);
      rst = 1'b0;
      idle(2);

      // Table of frames with cmd_ready held high
      cmd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].exp_cmd) exp_cmd_q.push_back('{vecs[i].code, vecs[i].arg});
         if (vecs[i].exp_err) exp_err_q.push_back(vecs[i].ecode);
         for (int j = 0; j < vecs[i].n; j++) begin
            send(vecs[i].bytes[39-8*j -: 8]);
            if (j != vecs[i].n - 1) idle(1);
         end
         chk($sformatf("vec%0d_cmd_valid_lat", i), 32'(cmd_valid), 32'(vecs[i].exp_cmd));
         chk($sformatf("vec%0d_err_valid_lat", i), 32'(err_valid), 32'(vecs[i].exp_err));
         idle(3);
      end

      // Overrun while holding: command kept, handshake later
      cmd_ready = 1'b0;
      exp_cmd_q.push_back('{8'h6C, 8'h00});
      send(8'hAA); idle(1);
      send(8'h6C); idle(1);
      send(8'h00); idle(1);
      send(8'h6C); idle(1);
      exp_err_q.push_back(2'b10);
      send(8'h55);
      idle(3);
      chk("ovr_cmd_code", 32'(cmd_code), 32'h6C);
      chk("ovr_cmd_arg", 32'(cmd_arg), 32'h00);
      chk("ovr_still_valid", 32'(cmd_valid), 1);
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
      chk("ovr_released", 32'(cmd_valid), 0);
      idle(2);

      // Overrun byte and accepting handshake in the same cycle
      exp_cmd_q.push_back('{8'h12, 8'h34});
      send(8'hAA); idle(1);
      send(8'h12); idle(1);
      send(8'h34); idle(1);
      send(8'h26); idle(1);
      exp_err_q.push_back(2'b10);
      rx_data   = 8'h77;
      rx_valid  = 1'b1;
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_valid  = 1'b0;
      cmd_ready = 1'b0;
      chk("same_cycle_idle", 32'(cmd_valid), 0);
      idle(3);

      // Reset mid-frame, then a clean frame
      cmd_ready = 1'b1;
      send(8'hAA); idle(1);
      send(8'hF1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cmd_valid", 32'(cmd_valid), 0);
      chk("midrst_err_valid", 32'(err_valid), 0);
      chk("midrst_cmd_code", 32'(cmd_code), 0);
      chk("midrst_cmd_arg", 32'(cmd_arg), 0);
      chk("midrst_err_code", 32'(err_code), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      exp_cmd_q.push_back('{8'hF1, 8'h22});
      send(8'hAA); idle(1);
      send(8'hF1); idle(1);
      send(8'h22); idle(1);
      send(8'hD3);
      chk("postrst_cmd_valid", 32'(cmd_valid), 1);
      idle(3);

      // Inter-byte timeout
      send(8'hAA); idle(1);
      send(8'hF0);
      idle(90);
`ifdef UART_CMD_TIMEOUT_EN
      exp_err_q.push_back(2'b11);
      idle(20);
      exp_cmd_q.push_back('{8'hF1, 8'h22});
      send(8'hAA); idle(1);
      send(8'hF1); idle(1);
      send(8'h22); idle(1);
      send(8'hD3);
      chk("tmo_recover_valid", 32'(cmd_valid), 1);
`else
      idle(20);
      exp_cmd_q.push_back('{8'hF0, 8'h22});
      send(8'h22); idle(1);
      send(8'hD2);
      chk("notmo_wait_valid", 32'(cmd_valid), 1);
`endif
      idle(5);

      chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
      chk("err_queue_drained", 32'(exp_err_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
